usb_fifo_ctrl: RTL and testbench

Sequences readout of the ADC capture buffer into the USB controller's slave FIFO. After a capture completes, it fetches samples one at a time from the capture buffer and left-justifies each into a 16-bit bus word. It strobes each word into the USB FIFO under full-flag flow control and optionally commits a trailing short packet. It sits between the capture buffer read port and the USB chip's slave FIFO pins, in the `rdclk` domain.

---
 rtl/usb_fifo_ctrl.sv | 177 +++++++++++++++++
 tb/tb_usb_fifo_ctrl.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/usb_fifo_ctrl.sv
// usb_fifo_ctrl
// ---------------------------------------------------------------------------
// Reads samples out of the ADC capture buffer once a capture completes. Each
// sample is left-justified into a 16-bit word and strobed into the USB
// controller's slave FIFO, with flow control from the FIFO full flag.
//
// Optional feature macro: USB_PKTEND_EN
//   defined   - a short final packet (packet count != 0 at the end of the
//               transfer) is committed with a pktend_n strobe
//   undefined - no PKTEND state; pktend_n is tied high
//
// Parameters
//   DATA_W   : sample width (<= 16); word = {sample, (16-DATA_W)'b0}
//   XFER_LEN : words per transfer (1..65535)
//   PKT_LEN  : USB packet size in words (1..65535)
//
// Ports
//   rdclk       : clock, everything on the rising edge
//   rst         : asynchronous active-high reset
//   start       : capture-complete pulse, honoured only while idle
//   abort       : synchronous return to idle from any state
//   buf_empty   : capture buffer empty
//   buf_rd      : capture buffer read strobe (data valid next cycle)
//   buf_data    : capture buffer read data
//   flag_full_n : USB FIFO full flag, active low
//   dout        : registered USB FIFO data bus
//   slwr_n      : USB FIFO write strobe, active low
//   pktend_n    : USB packet-end strobe, active low
//   busy        : high whenever not idle
//   done        : one-cycle pulse at the end of a transfer
// ---------------------------------------------------------------------------
module usb_fifo_ctrl #(
  parameter int DATA_W   = 11,
  parameter int XFER_LEN = 16384,
  parameter int PKT_LEN  = 256
) (
  input  logic              rdclk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic              buf_empty,
  output logic              buf_rd,
  input  logic [DATA_W-1:0] buf_data,
  input  logic              flag_full_n,
  output logic [15:0]       dout,
  output logic              slwr_n,
  output logic              pktend_n,
  output logic              busy,
  output logic              done
);

  localparam int PAD_W = 16 - DATA_W;
  localparam logic [15:0] XFER_LAST = 16'(XFER_LEN - 1);
  localparam logic [15:0] PKT_LAST  = 16'(PKT_LEN - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_LOAD,
    S_WRITE,
    S_END,
    S_PKTEND,
    S_DONE
  } state_t;

  state_t      state_reg, state_next;
  logic [15:0] word_cnt_reg, word_cnt_next;
  logic [15:0] pkt_cnt_reg, pkt_cnt_next;
  logic [15:0] word_pad;

  // Left-justify the sample; the low PAD_W bits are zero.
  genvar gi;
  generate
    for (gi = 0; gi < 16; gi++) begin : g_pad
      if (gi >= PAD_W) begin : g_data
        assign word_pad[gi] = buf_data[gi-PAD_W];
      end else begin : g_zero
        assign word_pad[gi] = 1'b0;
      end
    end
  endgenerate

  always_ff @(posedge rdclk or posedge rst) begin
    if (rst) begin
      state_reg    <= S_IDLE;
      word_cnt_reg <= '0;
      pkt_cnt_reg  <= '0;
      dout         <= '0;
    end else begin
      state_reg    <= state_next;
      word_cnt_reg <= word_cnt_next;
      pkt_cnt_reg  <= pkt_cnt_next;
      // Registering here (one cycle ahead of the strobe) gives the FX2 its
      // data setup time; an abort leaves the last word on the bus.
      if (state_reg == S_LOAD && !abort) begin
        dout <= word_pad;
      end
    end
  end

  always_comb begin
    state_next    = state_reg;
    word_cnt_next = word_cnt_reg;
    pkt_cnt_next  = pkt_cnt_reg;
    buf_rd        = 1'b0;
    slwr_n        = 1'b1;
    pktend_n      = 1'b1;
    done          = 1'b0;

    case (state_reg)
      S_IDLE: begin
        if (start) begin
          word_cnt_next = '0;
          pkt_cnt_next  = '0;
          state_next    = S_FETCH;
        end
      end

      S_FETCH: begin
        if (!buf_empty) begin
          buf_rd     = 1'b1;
          state_next = S_LOAD;
        end
      end

      S_LOAD: begin
        state_next = S_WRITE;
      end

      S_WRITE: begin
        // Strobe is combinational on the full flag so it can never be low
        // in a cycle where the FIFO reports full.
        if (flag_full_n) begin
          slwr_n        = 1'b0;
          word_cnt_next = word_cnt_reg + 16'd1;
          pkt_cnt_next  = (pkt_cnt_reg == PKT_LAST) ? 16'd0 : pkt_cnt_reg + 16'd1;
          // Compare against the pre-increment count so the counter never
          // needs to represent XFER_LEN itself beyond 16 bits.
          state_next    = (word_cnt_reg == XFER_LAST) ? S_END : S_FETCH;
        end
      end

      S_END: begin
`ifdef USB_PKTEND_EN
        state_next = (pkt_cnt_reg != 16'd0) ? S_PKTEND : S_DONE;
`else
        state_next = S_DONE;
`endif
      end

`ifdef USB_PKTEND_EN
      S_PKTEND: begin
        if (flag_full_n) begin
          pktend_n   = 1'b0;
          state_next = S_DONE;
        end
      end
`endif

      S_DONE: begin
        done       = 1'b1;
        state_next = S_IDLE;
      end

      default: begin
        state_next = S_IDLE;
      end
    endcase

    if (abort) begin
      state_next = S_IDLE;
    end
  end

  assign busy = (state_reg != S_IDLE);

endmodule

// File: tb/tb_usb_fifo_ctrl.sv
// Self-checking bench for usb_fifo_ctrl. A small capture-buffer model feeds
// samples and pushes the expected bus word into a scoreboard queue on every
// read; each observed slwr_n strobe pops and compares dout.
module tb_usb_fifo_ctrl;

  localparam int DATA_W   = 11;
  localparam int XFER_LEN = 10;
  localparam int PKT_LEN  = 4;
  localparam int PAD_W    = 16 - DATA_W;
`ifdef USB_PKTEND_EN
  localparam bit PKT_ON = 1'b1;
`else
  localparam bit PKT_ON = 1'b0;
`endif
  localparam int EXP_PKT      = (PKT_ON && ((XFER_LEN % PKT_LEN) != 0)) ? 1 : 0;
  localparam int EXP_DONE_LAG = 2 + EXP_PKT;

  logic              rdclk = 1'b0;
  logic              rst, start, abort, buf_empty, buf_rd, flag_full_n;
  logic [DATA_W-1:0] buf_data;
  logic [15:0]       dout;
  logic              slwr_n, pktend_n, busy, done;

  usb_fifo_ctrl #(.DATA_W(DATA_W), .XFER_LEN(XFER_LEN), .PKT_LEN(PKT_LEN)) dut (
    .rdclk(rdclk), .rst(rst), .start(start), .abort(abort),
    .buf_empty(buf_empty), .buf_rd(buf_rd), .buf_data(buf_data),
    .flag_full_n(flag_full_n), .dout(dout), .slwr_n(slwr_n),
    .pktend_n(pktend_n), .busy(busy), .done(done)
  );

  always #5 rdclk = ~rdclk;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;
  always @(posedge rdclk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  // ---------------- capture buffer model + scoreboard producer -------------
  logic [DATA_W-1:0] samples [0:63];
  int                rd_idx = 0;
  bit                empty_hold = 1'b0;
  logic [15:0]       exp_q [$];

  assign buf_empty = empty_hold || (rd_idx >= XFER_LEN);

  always begin : buf_model
    bit rd_seen;
    @(negedge rdclk);
    rd_seen = buf_rd;
    @(posedge rdclk);
    #1;
    if (rd_seen) begin
      buf_data = samples[rd_idx];
      exp_q.push_back({samples[rd_idx], {PAD_W{1'b0}}});
      rd_idx++;
    end
  end

  // ---------------- output monitor / scoreboard consumer -------------------
  int          strobe_cnt, pktend_cnt, done_cnt;
  int          last_strobe_cyc, last_pktend_cyc, first_strobe_cyc;
  logic [15:0] dout_log [0:15];

  always @(negedge rdclk) begin : monitor
    logic [15:0] exp_w;
    if (!rst) begin
      if (!slwr_n) begin
        check("slwr_while_full", flag_full_n, 1);
        check("slwr_pktend_overlap", pktend_n, 1);
        if (exp_q.size() > 0) begin
          exp_w = exp_q.pop_front();
          check("dout", dout, exp_w);
        end else begin
          check("sb_depth", exp_q.size(), 1);
        end
        if (strobe_cnt < 16) dout_log[strobe_cnt] = dout;
        if (strobe_cnt == 0) first_strobe_cyc = cyc;
        strobe_cnt++;
        last_strobe_cyc = cyc;
        $display("cycle %0d: strobe %0d dout=%04h", cyc, strobe_cnt, dout);
      end
      if (!pktend_n) begin
        check("pktend_while_full", flag_full_n, 1);
        pktend_cnt++;
        last_pktend_cyc = cyc;
        $display("cycle %0d: pktend", cyc);
      end
      if (done) begin
        done_cnt++;
        $display("cycle %0d: done", cyc);
      end
    end
  end

  // ---------------- helpers ------------------------------------------------
  task automatic drive_tick();
    @(posedge rdclk);
    #1;
  endtask

  task automatic clear_stats();
    strobe_cnt       = 0;
    pktend_cnt       = 0;
    done_cnt         = 0;
    last_strobe_cyc  = -100;
    last_pktend_cyc  = -100;
    first_strobe_cyc = -1;
    exp_q.delete();
    rd_idx = 0;
  endtask

  task automatic pulse_start(output int sc);
    start = 1'b1;
    sc    = cyc;
    drive_tick();
    start = 1'b0;
  endtask

  task automatic wait_strobes(input int n, input string tag);
    int seen = 0;
    int t    = 0;
    while (seen < n && t < 300) begin
      @(negedge rdclk);
      if (!slwr_n) seen++;
      t++;
    end
    check(tag, seen, n);
  endtask

  task automatic finish_xfer(input string tag);
    int dcyc = -1;
    int t    = 0;
    while (dcyc < 0 && t < 400) begin
      @(negedge rdclk);
      if (done === 1'b1) dcyc = cyc;
      t++;
    end
    if (dcyc < 0) check({tag, "_done_timeout"}, done, 1);
    repeat (3) @(negedge rdclk);
    check({tag, "_strobes"}, strobe_cnt, XFER_LEN);
    check({tag, "_pktends"}, pktend_cnt, EXP_PKT);
    check({tag, "_dones"}, done_cnt, 1);
    check({tag, "_done_lag"}, dcyc - last_strobe_cyc, EXP_DONE_LAG);
    if (pktend_cnt != 0) check({tag, "_pktend_to_done"}, dcyc - last_pktend_cyc, 1);
    check({tag, "_sb_drained"}, exp_q.size(), 0);
    drive_tick();
  endtask

  // ---------------- stimulus -----------------------------------------------
  logic [15:0] basic_exp [0:3];
  int          sc;

  initial begin
    basic_exp[0] = 16'h0020;
    basic_exp[1] = 16'hFFE0;
    basic_exp[2] = 16'h8000;
    basic_exp[3] = 16'h2AA0;

    rst = 1'b1; start = 1'b0; abort = 1'b0; flag_full_n = 1'b1;
    buf_data = '0;
    for (int i = 0; i < 64; i++) samples[i] = DATA_W'($urandom_range(0, 2047));
    samples[0] = 11'h001;
    samples[1] = 11'h7FF;
    samples[2] = 11'h400;
    samples[3] = 11'h155;
    clear_stats();

    // Reset state
    repeat (2) drive_tick();
    @(negedge rdclk);
    check("rst_dout", dout, 16'h0000);
    check("rst_slwr_n", slwr_n, 1);
    check("rst_pktend_n", pktend_n, 1);
    check("rst_buf_rd", buf_rd, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    drive_tick();
    rst = 1'b0;
    repeat (2) drive_tick();

    // Basic transfer with known sample values
    pulse_start(sc);
    finish_xfer("basic");
    check("first_strobe_latency", first_strobe_cyc - sc, 3);
    for (int i = 0; i < 4; i++) check("basic_word", dout_log[i], basic_exp[i]);

    // Full-flag flow control: stall 10 cycles in WRITE on the second word
    clear_stats();
    pulse_start(sc);
    begin
      int n = 0;
      int t = 0;
      logic [15:0] held;
      while (n < 2 && t < 100) begin
        @(negedge rdclk);
        if (buf_rd) n++;
        t++;
      end
      check("fc_fetch_seen", n, 2);
      drive_tick();
      flag_full_n = 1'b0;
      @(negedge rdclk);
      held = dout;
      for (int k = 0; k < 10; k++) begin
        @(negedge rdclk);
        if (k == 0) begin
          held = dout;
          check("fc_dout_loaded", dout, {samples[1], {PAD_W{1'b0}}});
        end else begin
          check("fc_dout_hold", dout, held);
        end
        check("fc_slwr_hold", slwr_n, 1);
      end
      drive_tick();
      flag_full_n = 1'b1;
      @(negedge rdclk);
      check("fc_strobe_on_release", slwr_n, 0);
      @(negedge rdclk);
      check("fc_single_strobe", slwr_n, 1);
    end
    finish_xfer("flowctl");

    // Empty buffer stall mid-transfer, plus a start pulse while busy
    for (int i = 0; i < 64; i++) samples[i] = DATA_W'($urandom_range(0, 2047));
    clear_stats();
    pulse_start(sc);
    wait_strobes(4, "empty_pre_strobes");
    drive_tick();
    empty_hold = 1'b1;
    start      = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge rdclk);
      check("empty_no_rd", buf_rd, 0);
      check("empty_busy", busy, 1);
      drive_tick();
      if (k == 0) start = 1'b0;
    end
    empty_hold = 1'b0;
    finish_xfer("empty");

    // Abort after three words, then a full transfer from zero
    clear_stats();
    pulse_start(sc);
    wait_strobes(3, "abort_pre_strobes");
    drive_tick();
    abort = 1'b1;
    drive_tick();
    abort = 1'b0;
    @(negedge rdclk);
    check("abort_busy", busy, 0);
    check("abort_slwr_n", slwr_n, 1);
    check("abort_done", done, 0);
    repeat (5) @(negedge rdclk);
    check("abort_no_done", done_cnt, 0);
    check("abort_strobes", strobe_cnt, 3);
    drive_tick();
    clear_stats();
    pulse_start(sc);
    finish_xfer("post_abort");

    // Asynchronous reset in the middle of a write strobe
    clear_stats();
    pulse_start(sc);
    wait_strobes(2, "rst_pre_strobes");
    #1 rst = 1'b1;
    #1;
    check("arst_slwr_n", slwr_n, 1);
    check("arst_busy", busy, 0);
    check("arst_dout", dout, 16'h0000);
    check("arst_buf_rd", buf_rd, 0);
    check("arst_pktend_n", pktend_n, 1);
    check("arst_done", done, 0);
    repeat (2) drive_tick();
    rst = 1'b0;
    repeat (3) drive_tick();
    clear_stats();
    pulse_start(sc);
    finish_xfer("post_rst");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d vectors applied", n_vec);
    $fatal(1);
  end

endmodule
